fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction prefetch buffer between the instruction memory (im) and the instruction register (ir) of the SISC core. It generates sequential word addresses, issues at most one outstanding fetch at a time, and buffers returned instruction words with their PC in a small FIFO. It presents them to the core with a valid/ready handshake, so ir_load stalls no longer block fetch. A flush input discards all buffered and in-flight instructions and redirects fetch on a taken branch.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 16'h0000, fetch address after reset
ADDR_W, 16, PC/address width
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock, all state on rising edge
rst_f  input  1  synchronous reset, active-high: sampled on rising clk, 1 = reset
im_req  output  1  fetch request strobe, one cycle per request
im_addr  output  ADDR_W  fetch word address, valid while im_req=1
im_rdata  input  DATA_W  returned instruction word
im_rvalid  input  1  im_rdata valid, in order, >= 1 cycle after im_req
instr_out  output  DATA_W  head instruction to ir
instr_pc  output  ADDR_W  PC of head instruction
instr_valid  output  1  head entry present
instr_ready  input  1  core consumes head this cycle (ir_load)
flush  input  1  discard everything, refetch from flush_pc
flush_pc  input  ADDR_W  redirect target
count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_f=1 at edge): fetch_pc=RESET_PC, FIFO empty, count=0, state IDLE, im_req=0, instr_valid=0, instr_out=0, instr_pc=0. Reset mid-operation abandons any in-flight request. im_rvalid received in IDLE is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, response to be kept.
  - DROP: one request outstanding, response to be discarded.
- IDLE: im_req=1 (combinational, same cycle) iff count < DEPTH and flush=0. im_addr=fetch_pc. On issue, latch req_pc=fetch_pc, fetch_pc <= fetch_pc+1 mod 2^ADDR_W (16'hFFFF wraps to 16'h0000), go to WAIT.
- WAIT: im_req=0. On im_rvalid, push {im_rdata, req_pc}, then go to IDLE. The next request may issue the cycle after the response, giving max throughput of 1 instruction per 2 cycles at 1-cycle memory latency.
- Issue rule guarantees space: count + outstanding <= DEPTH. A push never occurs at full. Issuing a request when count=DEPTH is an error and must not happen.
- Pop: instr_valid && instr_ready in the same cycle removes the head at the edge. Simultaneous push and pop leaves count unchanged. Pop with instr_valid=0 is ignored.
- Head outputs are registered from FIFO storage. Latency from im_rvalid to instr_valid is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- flush=1 (highest priority after reset):
  - FIFO cleared, count=0.
  - fetch_pc <= flush_pc.
  - Same-cycle push/pop are discarded.
  - State: IDLE->IDLE, WAIT->DROP (or IDLE if im_rvalid arrives that same cycle), DROP stays DROP.
  - No request is issued in the flush cycle.
- DROP: im_rvalid is discarded, go to IDLE. A flush in DROP only updates fetch_pc.
- instr_valid=0 in the cycle after a flush unless bypass (below) applies.

Optional Feature:
FQ_BYPASS_EN. When defined: if the FIFO is empty, state is WAIT, im_rvalid=1 and flush=0, then instr_out/instr_pc/instr_valid are driven combinationally from im_rdata/req_pc in that cycle. If instr_ready=1 as well, the word is consumed and not pushed, giving 0-cycle latency. When undefined: outputs are purely registered, with a fixed 1-cycle fill latency.

Test Plan:
- Reset then 1-cycle-latency memory returning 32'hA000_0000+addr, instr_ready=1 -> im_addr 0,1,2,... on every other cycle; instr_out/instr_pc pairs (32'hA000_0000,0),(32'hA000_0001,1),... in order, count never exceeds 1.
- instr_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests issued, count=4, im_req stays 0. Raise ready -> PCs 0..3 drain, then fetch resumes at 4.
- Memory latency 3 cycles, flush with flush_pc=16'h0040 while in WAIT -> late response dropped; next im_addr=16'h0040; first instr_pc=16'h0040; no stale word ever reaches instr_valid.
- RESET_PC=16'hFFFE, free-running -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- rst_f asserted while FIFO holds 3 entries and a request is outstanding -> next cycle count=0, instr_valid=0. The pending im_rvalid is ignored; first post-reset im_addr=RESET_PC.
- FQ_BYPASS_EN defined, empty FIFO, instr_ready=1 -> instr_valid asserts in the same cycle as im_rvalid and count stays 0. Undefined -> instr_valid asserts 1 cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between instruction memory and the IR: one outstanding fetch, DEPTH-entry FIFO.
// Define FQ_BYPASS_EN to forward a response straight to the head outputs when the FIFO is empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_f,
    output logic                     im_req,
    output logic [ADDR_W-1:0]        im_addr,
    input  logic [DATA_W-1:0]        im_rdata,
    input  logic                     im_rvalid,
    output logic [DATA_W-1:0]        instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        flush_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic push;
    logic pop;
    logic bypass;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        im_req      = 1'b0;
        im_addr     = fetch_pc_q;
        push        = 1'b0;
        bypass      = 1'b0;
        instr_valid = (count_q != '0);
        instr_out   = mem_data_q[rd_ptr_q];
        instr_pc    = mem_pc_q[rd_ptr_q];

`ifdef FQ_BYPASS_EN
        if (count_q == '0 && state_q == S_WAIT && im_rvalid && !flush) begin
            bypass      = 1'b1;
            instr_valid = 1'b1;
            instr_out   = im_rdata;
            instr_pc    = req_pc_q;
        end
`else
        bypass = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!flush && count_q < FULL_CNT) begin
                    im_req     = 1'b1;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A bypassed word that is consumed this cycle never enters the FIFO.
                if (im_rvalid) begin
                    state_d = S_IDLE;
                    push    = !flush && !(bypass && instr_ready);
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (im_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop = (count_q != '0) && instr_ready && !flush;

        if (flush) begin
            fetch_pc_d = flush_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                mem_data_q[wr_ptr_q] <= im_rdata;
                mem_pc_q[wr_ptr_q]   <= req_pc_q;
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: queue-based reference model plus a latency-configurable memory model.
// Honours FQ_BYPASS_EN the same way as the design.
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'hFFFE;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_f, im_req, im_rvalid, instr_valid, instr_ready, flush;
    logic [15:0] im_addr, instr_pc, flush_pc;
    logic [31:0] im_rdata, instr_out;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH(DEPTH),
        .ADDR_W(16),
        .DATA_W(32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst_f(rst_f),
        .im_req(im_req),
        .im_addr(im_addr),
        .im_rdata(im_rdata),
        .im_rvalid(im_rvalid),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .flush(flush),
        .flush_pc(flush_pc),
        .count(count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] pc;
    } ent_t;

    // reference model: buffered words, one outstanding request that may be marked for discard
    ent_t        q[$];
    bit          m_out  = 1'b0;
    bit          m_drop = 1'b0;
    logic [15:0] m_fetch  = '0;
    logic [15:0] m_req_pc = '0;

    // memory model
    bit          mem_busy  = 1'b0;
    bit          mem_stale = 1'b0;
    int          mem_cnt   = 0;
    logic [15:0] mem_addr  = '0;
    int          lat_min   = 1;
    int          lat_max   = 1;

    // observations
    logic [15:0] pops[$];
    logic [15:0] reqs[$];
    int          max_cnt = 0;
    bit          byp_seen = 1'b0;
    logic        byp_valid_obs;
    logic [2:0]  byp_cnt_obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        bit   byp, ev, er, pop, push;
        ent_t e;
        #1;
        byp = BYP && q.size() == 0 && m_out && !m_drop && im_rvalid && !flush;
        ev  = (q.size() > 0) || byp;
        er  = !m_out && q.size() < DEPTH && !flush;
        if (armed) begin
            chk("im_req", im_req, er);
            if (er) chk("im_addr", im_addr, m_fetch);
            chk("instr_valid", instr_valid, ev);
            if (ev) begin
                if (byp) begin
                    e.data = im_rdata;
                    e.pc   = m_req_pc;
                end else begin
                    e = q[0];
                end
                chk("instr_out", instr_out, e.data);
                chk("instr_pc", instr_pc, e.pc);
            end
            chk("count", count, q.size());
            if (!rst_f && instr_valid && instr_ready) pops.push_back(instr_pc);
            if (!rst_f && im_req) reqs.push_back(im_addr);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (!byp_seen && !rst_f && !flush && im_rvalid && m_out && !m_drop && q.size() == 0) begin
                byp_seen      = 1'b1;
                byp_valid_obs = instr_valid;
                byp_cnt_obs   = count;
            end
        end

        if (rst_f) begin
            q.delete();
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_fetch = RST_PC;
        end else if (flush) begin
            q.delete();
            m_fetch = flush_pc;
            if (m_out && im_rvalid) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            pop  = ev && instr_ready;
            push = m_out && !m_drop && im_rvalid && !(byp && instr_ready);
            if (m_out && im_rvalid) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (pop && !byp) void'(q.pop_front());
            if (push) begin
                e.data = im_rdata;
                e.pc   = m_req_pc;
                q.push_back(e);
            end
            if (er) begin
                m_out    = 1'b1;
                m_req_pc = m_fetch;
                m_fetch  = m_fetch + 16'd1;
            end
        end

        if (rst_f) begin
            mem_stale = mem_busy;
            mem_busy  = 1'b0;
        end else if (im_req) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_addr = im_addr;
        end

        @(negedge clk);
        im_rvalid = 1'b0;
        im_rdata  = $urandom;
        if (mem_stale) begin
            im_rvalid = 1'b1;
            im_rdata  = 32'hDEAD_BEEF;
            mem_stale = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                im_rvalid = 1'b1;
                im_rdata  = 32'hA000_0000 + {16'h0000, mem_addr};
                mem_busy  = 1'b0;
            end
        end
    endtask

    logic [15:0] exp_wrap [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bit          found;

    initial begin
        rst_f       = 1'b1;
        flush       = 1'b0;
        flush_pc    = '0;
        instr_ready = 1'b0;
        im_rvalid   = 1'b0;
        im_rdata    = '0;
        @(negedge clk);
        cycle();
        armed = 1'b1;
        cycle();

        // post-reset state and first fetch address
        rst_f       = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_req", im_req, 1);
        chk("rst_addr", im_addr, 16'hFFFE);

        // free-running across the address wrap, 1-cycle memory
        pops.delete();
        max_cnt = 0;
        repeat (12) cycle();
        chk("wrap_pop_count", pops.size() >= 4, 1);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("wrap_pc", pops[i], exp_wrap[i]);
        chk("max_count_le1", max_cnt <= 1, 1);
        chk("fill_seen", byp_seen, 1);
        chk("fill_valid_same_cycle", byp_valid_obs, BYP);
        chk("fill_count", byp_cnt_obs, 0);

        // back-pressure: FIFO fills to DEPTH and fetch stops
        instr_ready = 1'b0;
        flush       = 1'b1;
        flush_pc    = 16'h0000;
        cycle();
        flush = 1'b0;
        reqs.delete();
        repeat (20) cycle();
        chk("bp_reqs", reqs.size(), 4);
        chk("bp_count", count, 4);
        chk("bp_req_idle", im_req, 0);
        instr_ready = 1'b1;
        pops.delete();
        repeat (14) cycle();
        chk("bp_pop_count", pops.size() >= 5, 1);
        for (int i = 0; i < 5 && i < pops.size(); i++) chk("bp_pc", pops[i], i);

        // flush while a 3-cycle fetch is outstanding
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out && !m_drop && !im_rvalid) found = 1'b1;
            else cycle();
        end
        chk("flush_wait_found", found, 1);
        flush    = 1'b1;
        flush_pc = 16'h0040;
        cycle();
        flush = 1'b0;
        reqs.delete();
        pops.delete();
        repeat (16) cycle();
        chk("flush_req_seen", reqs.size() >= 1, 1);
        if (reqs.size() >= 1) chk("flush_first_addr", reqs[0], 16'h0040);
        chk("flush_pop_seen", pops.size() >= 1, 1);
        if (pops.size() >= 1) chk("flush_first_pc", pops[0], 16'h0040);

        // randomised traffic with flushes and occasional resets
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            flush_pc    = 16'($urandom);
            rst_f       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst_f = 1'b0;
        flush = 1'b0;

        // reset with three buffered entries and a fetch outstanding
        instr_ready = 1'b0;
        flush       = 1'b1;
        flush_pc    = 16'h0100;
        cycle();
        flush   = 1'b0;
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (q.size() == 3 && m_out && !im_rvalid) found = 1'b1;
            else cycle();
        end
        chk("rst_mid_found", found, 1);
        rst_f = 1'b1;
        cycle();
        rst_f = 1'b0;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_valid", instr_valid, 0);
        chk("rst_mid_stale_applied", im_rvalid, 1);
        chk("rst_mid_req", im_req, 1);
        chk("rst_mid_addr", im_addr, RST_PC);
        instr_ready = 1'b1;
        pops.delete();
        repeat (12) cycle();
        chk("rst_mid_pop_seen", pops.size() >= 1, 1);
        if (pops.size() >= 1) chk("rst_mid_first_pc", pops[0], RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
